// File: rtl/fp32_operand_rx_packer.sv
// 8N1 UART receiver that packs 12 bytes into one 96-bit {acc, bravo, alpha} operand word
// and presents it on a valid/ready handshake with a single output holding register.
module fp32_operand_rx_packer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        UART_RX_I,
  input  logic        RX_READY_I,
  output logic        RX_VALID_O,
  output logic [95:0] RX_DATA_O,
  output logic        FRAME_ERR_O,
  output logic        OVERRUN_O
);

  localparam int unsigned CntW      = $clog2(CLKS_PER_BIT);
  localparam int unsigned TmoCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TmoW      = $clog2(TmoCycles + 1);

  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TmoCycles - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [95:0]     shadow_q, shadow_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            valid_q, valid_d;
  logic [95:0]     data_q, data_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            word_done;
  logic            xfer;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    shadow_d    = shadow_q;
    tmo_d       = tmo_q;
    valid_d     = valid_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    word_done   = 1'b0;
    xfer        = valid_q & RX_READY_I;

    case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A line that is high again at mid-start was only a glitch.
          state_d   = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_sync_q) begin
            shadow_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
            if (byte_cnt_q == 4'd11) begin
              byte_cnt_d = 4'd0;
              word_done  = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Idle gap timer: only runs with a partial word pending and the line idle.
    if (state_q == StIdle && byte_cnt_q != 4'd0 && rx_sync_q) begin
      if (tmo_q == TmoLast) begin
        tmo_d      = '0;
        byte_cnt_d = 4'd0;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    if (word_done && (!valid_q || xfer)) begin
      data_d  = shadow_d;
      valid_d = 1'b1;
    end else begin
      overrun_d = word_done;
      if (xfer) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      byte_cnt_q  <= 4'd0;
      shadow_q    <= 96'd0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= 96'd0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= UART_RX_I;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      shadow_q    <= shadow_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign RX_VALID_O  = valid_q;
  assign RX_DATA_O   = data_q;
  assign FRAME_ERR_O = frame_err_q;
  assign OVERRUN_O   = overrun_q;

endmodule

// File: tb/tb_fp32_operand_rx_packer.sv
// Directed bench for fp32_operand_rx_packer: table of 12-byte words plus hand-written
// sequences for reset, backpressure/overrun, frame error, glitch and timeout.
module tb_fp32_operand_rx_packer;

  localparam int unsigned Cpb = 8;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        UART_RX_I;
  logic        RX_READY_I;
  logic        RX_VALID_O;
  logic [95:0] RX_DATA_O;
  logic        FRAME_ERR_O;
  logic        OVERRUN_O;

  fp32_operand_rx_packer #(
    .CLKS_PER_BIT(Cpb),
    .TIMEOUT_BITS(20)
  ) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .UART_RX_I  (UART_RX_I),
    .RX_READY_I (RX_READY_I),
    .RX_VALID_O (RX_VALID_O),
    .RX_DATA_O  (RX_DATA_O),
    .FRAME_ERR_O(FRAME_ERR_O),
    .OVERRUN_O  (OVERRUN_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [0:11][7:0] b;
    logic [95:0]      exp;
  } vec_t;

  vec_t vecs [4];

  int checks = 0;
  int errors = 0;

  // Monitor state, sampled on the falling edge.
  int          cyc = 0;
  int          rise_cyc = 0;
  int          ov_cyc = 0;
  int          hi_run = 0;
  int          last_run = 0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  int          stab_viol = 0;
  int          start_cyc = 0;
  logic        valid_prev = 1'b0;
  logic        ready_prev = 1'b0;
  logic [95:0] data_prev = '0;
  logic [95:0] words [$];

  always @(negedge CLK_I) begin
    cyc = cyc + 1;
    if (RX_VALID_O && !valid_prev) rise_cyc = cyc;
    if (RX_VALID_O) begin
      hi_run = hi_run + 1;
    end else if (valid_prev) begin
      last_run = hi_run;
      hi_run = 0;
    end
    if (valid_prev && !ready_prev && !RST_I && (!RX_VALID_O || RX_DATA_O !== data_prev))
      stab_viol = stab_viol + 1;
    if (RX_VALID_O && RX_READY_I) words.push_back(RX_DATA_O);
    if (FRAME_ERR_O) fe_cnt = fe_cnt + 1;
    if (OVERRUN_O) begin
      ov_cnt = ov_cnt + 1;
      ov_cyc = cyc;
    end
    valid_prev = RX_VALID_O;
    ready_prev = RX_READY_I;
    data_prev  = RX_DATA_O;
  end

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // All line tasks are entered and left 1 time unit after a rising edge.
  task automatic line_bit(input logic v);
    UART_RX_I = v;
    repeat (Cpb) @(posedge CLK_I);
    #1;
  endtask

  task automatic idle(input int n);
    UART_RX_I = 1'b1;
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(stop_bit);
  endtask

  task automatic send_word(input vec_t v);
    for (int k = 0; k < 12; k++) send_byte(v.b[k], 1'b1);
  endtask

  task automatic check_one_word(input string name, input logic [95:0] exp);
    check({name, "_count"}, 96'(words.size()), 96'd1);
    if (words.size() >= 1) check({name, "_data"}, words[0], exp);
  endtask

  int fe0;
  int ov0;

  initial begin
    vecs[0] = '{b: {8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40,
                    8'h00, 8'h00, 8'h40, 8'h40},
                exp: 96'h40400000_40000000_3F800000};
    vecs[1] = '{b: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                    8'h09, 8'h0A, 8'h0B, 8'h0C},
                exp: 96'h0C0B0A09_08070605_04030201};
    vecs[2] = '{b: {8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB0, 8'hB1,
                    8'hB2, 8'hB3, 8'hB4, 8'hB5},
                exp: 96'hB5B4B3B2_B1B0AFAE_ADACABAA};
    vecs[3] = '{b: {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78,
                    8'h9A, 8'hBC, 8'hDE, 8'hF0},
                exp: 96'hF0DEBC9A_78563412_EFBEADDE};

    // Reset values.
    RST_I = 1'b1;
    UART_RX_I = 1'b1;
    RX_READY_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    #1;
    check("rst_valid", 96'(RX_VALID_O), 96'd0);
    check("rst_data", RX_DATA_O, 96'd0);
    check("rst_frame_err", 96'(FRAME_ERR_O), 96'd0);
    check("rst_overrun", 96'(OVERRUN_O), 96'd0);
    RST_I = 1'b0;
    idle(10);

    // Reset mid-word and mid-byte discards the partial word.
    for (int k = 0; k < 3; k++) send_byte(vecs[1].b[k], 1'b1);
    line_bit(1'b0);
    line_bit(1'b1);
    RST_I = 1'b1;
    idle(5);
    check("midrst_valid", 96'(RX_VALID_O), 96'd0);
    check("midrst_data", RX_DATA_O, 96'd0);
    RST_I = 1'b0;
    idle(20);
    check("midrst_no_word", 96'(words.size()), 96'd0);
    check("midrst_no_fe", 96'(fe_cnt), 96'd0);

    // Table-driven words with the consumer always ready.
    RX_READY_I = 1'b1;
    for (int i = 0; i < 4; i++) begin
      words.delete();
      send_word(vecs[i]);
      idle(16);
      check_one_word($sformatf("vec%0d", i), vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 96'(rise_cyc - start_cyc), 96'd80);
      check($sformatf("vec%0d_valid_width", i), 96'(last_run), 96'd1);
    end

    // Backpressure: first word held, second dropped with an overrun pulse.
    RX_READY_I = 1'b0;
    words.delete();
    ov0 = ov_cnt;
    send_word(vecs[1]);
    idle(16);
    check("bp_valid_held", 96'(RX_VALID_O), 96'd1);
    check("bp_data_held", RX_DATA_O, vecs[1].exp);
    send_word(vecs[3]);
    idle(16);
    check("ov_pulses", 96'(ov_cnt - ov0), 96'd1);
    check("ov_timing", 96'(ov_cyc - start_cyc), 96'd80);
    check("ov_data_unchanged", RX_DATA_O, vecs[1].exp);
    check("ov_valid_still", 96'(RX_VALID_O), 96'd1);
    check("bp_stable", 96'(stab_viol), 96'd0);
    RX_READY_I = 1'b1;
    idle(4);
    check_one_word("bp_xfer", vecs[1].exp);
    check("bp_valid_drop", 96'(RX_VALID_O), 96'd0);

    // Frame error on byte 5 drops the partial word.
    words.delete();
    fe0 = fe_cnt;
    for (int k = 0; k < 5; k++) send_byte(vecs[0].b[k], 1'b1);
    send_byte(8'h5A, 1'b0);
    idle(16);
    send_word(vecs[1]);
    idle(16);
    check("fe_pulses", 96'(fe_cnt - fe0), 96'd1);
    check_one_word("fe_word", vecs[1].exp);

    // Start glitch shorter than half a bit.
    words.delete();
    fe0 = fe_cnt;
    UART_RX_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    #1;
    idle(24);
    check("glitch_no_word", 96'(words.size()), 96'd0);
    check("glitch_no_fe", 96'(fe_cnt - fe0), 96'd0);
    send_word(vecs[3]);
    idle(16);
    check_one_word("glitch_word", vecs[3].exp);

    // Timeout discards a 7-byte partial word.
    words.delete();
    for (int k = 0; k < 7; k++) send_byte(8'h11 + 8'(k), 1'b1);
    idle(170);
    send_word(vecs[2]);
    idle(16);
    check_one_word("timeout_word", 96'hB5B4B3B2_B1B0AFAE_ADACABAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
